// File: rtl/fetch_group.sv
// Frame-to-group fetcher: captures a parallel frame and issues GROUP-word windows
// advancing by STRIDE words per read, with no-bubble reload on the last read.
module fetch_group #(
  parameter int DW        = 16,
  parameter int FRAME_LEN = 20,
  parameter int GROUP     = 5,
  parameter int STRIDE    = 5,
  parameter int IW        = 3
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [DW*FRAME_LEN-1:0] frame_in,
  output logic                    load_ready,
  input  logic                    read_en,
  output logic [DW*GROUP-1:0]     group_out,
  output logic                    group_valid,
  output logic [IW-1:0]           group_idx,
  output logic                    empty,
  output logic                    underflow
);

  localparam int NG = (FRAME_LEN - GROUP) / STRIDE + 1;
  localparam int PW = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;
  localparam int FW = (DW * FRAME_LEN > 1) ? $clog2(DW * FRAME_LEN) : 1;
  localparam int CW = IW + 1;

  if ((GROUP < 1) || (GROUP > FRAME_LEN) || (STRIDE < 1) || (STRIDE > GROUP) ||
      (((FRAME_LEN - GROUP) % STRIDE) != 0) || ((1 << IW) < NG)) begin : g_param_check
    $error("fetch_group: illegal parameter combination");
  end

  typedef enum logic {ST_EMPTY, ST_ACTIVE} state_t;

  state_t                    state_reg;
  logic [DW*FRAME_LEN-1:0]   frame_reg;
  logic [PW-1:0]             ptr_reg;
  logic [CW-1:0]             cnt_reg;
  logic [DW*GROUP-1:0]       group_out_reg;
  logic                      group_valid_reg;
  logic [IW-1:0]             group_idx_reg;
  logic                      underflow_reg;

  logic [DW*GROUP-1:0]       window_next;
  logic                      last_read;
  logic                      load_accept;
  logic [PW-1:0]             ptr_next;
  logic [CW-1:0]             cnt_next;

  assign last_read   = (state_reg == ST_ACTIVE) && read_en && (cnt_reg == CW'(NG - 1));
  assign load_ready  = (state_reg == ST_EMPTY) || last_read;
  assign load_accept = load && load_ready;
  assign ptr_next    = ptr_reg + PW'(STRIDE);
  assign cnt_next    = cnt_reg + CW'(1);

  // Each window word is an independent part-select of the held frame.
  for (genvar gi = 0; gi < GROUP; gi++) begin : g_window
    logic [PW-1:0] word_idx;
    logic [FW-1:0] bit_base;
    assign word_idx = ptr_reg + PW'(gi);
    assign bit_base = FW'(word_idx) * FW'(DW);
    assign window_next[gi*DW +: DW] = frame_reg[bit_base +: DW];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg       <= ST_EMPTY;
      frame_reg       <= '0;
      ptr_reg         <= '0;
      cnt_reg         <= '0;
      group_out_reg   <= '0;
      group_valid_reg <= 1'b0;
      group_idx_reg   <= '0;
      underflow_reg   <= 1'b0;
    end else begin
      group_valid_reg <= 1'b0;
      underflow_reg   <= 1'b0;

      if (state_reg == ST_ACTIVE && read_en) begin
        group_out_reg   <= window_next;
        group_valid_reg <= 1'b1;
        group_idx_reg   <= cnt_reg[IW-1:0];
        if (last_read) begin
          state_reg <= ST_EMPTY;
          ptr_reg   <= '0;
          cnt_reg   <= '0;
        end else begin
          ptr_reg <= ptr_next;
          cnt_reg <= cnt_next;
        end
      end

      if (state_reg == ST_EMPTY && read_en) begin
        underflow_reg <= 1'b1;
      end

      // A same-cycle load overrides the end-of-frame transition above.
      if (load_accept) begin
        frame_reg <= frame_in;
        ptr_reg   <= '0;
        cnt_reg   <= '0;
        state_reg <= ST_ACTIVE;
      end
    end
  end

  assign group_out   = group_out_reg;
  assign group_valid = group_valid_reg;
  assign group_idx   = group_idx_reg;
  assign underflow   = underflow_reg;
  assign empty       = (state_reg == ST_EMPTY);

endmodule

// File: tb/tb_fetch_group.sv
// Directed table-driven bench for fetch_group: a default instance and an
// overlapping-window instance (FRAME_LEN=10, GROUP=4, STRIDE=2).
module tb_fetch_group;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  // Instance A: default parameters
  logic          a_load, a_read, a_lr, a_valid, a_empty, a_uf;
  logic [319:0]  a_frame;
  logic [79:0]   a_group;
  logic [2:0]    a_idx;

  // Instance B: overlapping windows
  logic          b_load, b_read, b_lr, b_valid, b_empty, b_uf;
  logic [159:0]  b_frame;
  logic [63:0]   b_group;
  logic [1:0]    b_idx;

  fetch_group dut_a (
    .clk(clk), .rst_n(rst_n), .load(a_load), .frame_in(a_frame), .load_ready(a_lr),
    .read_en(a_read), .group_out(a_group), .group_valid(a_valid), .group_idx(a_idx),
    .empty(a_empty), .underflow(a_uf)
  );

  fetch_group #(.DW(16), .FRAME_LEN(10), .GROUP(4), .STRIDE(2), .IW(2)) dut_b (
    .clk(clk), .rst_n(rst_n), .load(b_load), .frame_in(b_frame), .load_ready(b_lr),
    .read_en(b_read), .group_out(b_group), .group_valid(b_valid), .group_idx(b_idx),
    .empty(b_empty), .underflow(b_uf)
  );

  typedef struct {
    bit sel;     // 0 = instance A, 1 = instance B
    bit ld;
    bit rd;
    int fbase;   // frame word k = fbase + k
    bit lr;      // expected load_ready before the edge
    bit v;
    int idx;
    bit e;
    bit uf;
    int gbase;   // expected window word j = gbase + j; 0 means all-zero window
  } vec_t;

  vec_t tbl[$];
  int total = 0;
  int bad = 0;

  function automatic vec_t mk(bit sel, bit ld, bit rd, int fbase, bit lr,
                              bit v, int idx, bit e, bit uf, int gbase);
    vec_t r;
    r.sel = sel; r.ld = ld; r.rd = rd; r.fbase = fbase; r.lr = lr;
    r.v = v; r.idx = idx; r.e = e; r.uf = uf; r.gbase = gbase;
    return r;
  endfunction

  task automatic check(string name, logic [127:0] act, logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [127:0] exp_window(int gbase, int g);
    logic [127:0] w = '0;
    if (gbase != 0)
      for (int j = 0; j < g; j++) w[j*DW +: DW] = 16'(gbase + j);
    return w;
  endfunction

  task automatic check_reset_values(string tag);
    check({tag, "_a_empty"}, 128'(a_empty), 128'(1));
    check({tag, "_a_lr"},    128'(a_lr),    128'(1));
    check({tag, "_a_valid"}, 128'(a_valid), 128'(0));
    check({tag, "_a_idx"},   128'(a_idx),   128'(0));
    check({tag, "_a_uf"},    128'(a_uf),    128'(0));
    check({tag, "_a_group"}, 128'(a_group), 128'(0));
    check({tag, "_b_empty"}, 128'(b_empty), 128'(1));
    check({tag, "_b_group"}, 128'(b_group), 128'(0));
  endtask

  task automatic run_vec(int n, vec_t t);
    a_load = 0; a_read = 0; b_load = 0; b_read = 0;
    if (t.sel == 0) begin
      a_load = t.ld; a_read = t.rd;
      for (int k = 0; k < 20; k++) a_frame[k*DW +: DW] = 16'(t.fbase + k);
    end else begin
      b_load = t.ld; b_read = t.rd;
      for (int k = 0; k < 10; k++) b_frame[k*DW +: DW] = 16'(t.fbase + k);
    end
    #1;
    check($sformatf("v%0d_load_ready", n), 128'(t.sel ? b_lr : a_lr), 128'(t.lr));
    @(posedge clk);
    #1;
    if (t.sel == 0) begin
      check($sformatf("v%0d_valid", n), 128'(a_valid), 128'(t.v));
      check($sformatf("v%0d_idx", n),   128'(a_idx),   128'(t.idx));
      check($sformatf("v%0d_empty", n), 128'(a_empty), 128'(t.e));
      check($sformatf("v%0d_uf", n),    128'(a_uf),    128'(t.uf));
      check($sformatf("v%0d_group", n), 128'(a_group), exp_window(t.gbase, 5));
    end else begin
      check($sformatf("v%0d_valid", n), 128'(b_valid), 128'(t.v));
      check($sformatf("v%0d_idx", n),   128'(b_idx),   128'(t.idx));
      check($sformatf("v%0d_empty", n), 128'(b_empty), 128'(t.e));
      check($sformatf("v%0d_uf", n),    128'(b_uf),    128'(t.uf));
      check($sformatf("v%0d_group", n), 128'(b_group), exp_window(t.gbase, 4));
    end
    $display("vec %0d sel=%0d ld=%0d rd=%0d valid=%0d/%0d idx=%0d/%0d empty=%0d/%0d uf=%0d/%0d",
             n, t.sel, t.ld, t.rd, a_valid, b_valid, a_idx, b_idx, a_empty, b_empty, a_uf, b_uf);
  endtask

  initial begin
    //            sel ld rd fbase lr v idx e uf gbase
    // four windows of frame 1..20, then underflow and hold
    tbl.push_back(mk(0, 1, 0, 1,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 1, 0, 0, 6));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 2, 0, 0, 11));
    tbl.push_back(mk(0, 0, 1, 0,   1, 1, 3, 1, 0, 16));
    tbl.push_back(mk(0, 0, 1, 0,   1, 0, 3, 1, 1, 16));
    tbl.push_back(mk(0, 0, 0, 0,   1, 0, 3, 1, 0, 16));
    // load ignored while ACTIVE at cnt=1, then reload on the last read
    tbl.push_back(mk(0, 1, 0, 1,   1, 0, 3, 0, 0, 16));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 0, 201, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 1, 0, 0, 6));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 2, 0, 0, 11));
    tbl.push_back(mk(0, 1, 1, 101, 1, 1, 3, 0, 0, 16));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 0, 0, 0, 101));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 1, 0, 0, 106));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 2, 0, 0, 111));
    tbl.push_back(mk(0, 0, 1, 0,   1, 1, 3, 1, 0, 116));
    // load and read together while EMPTY: underflow, new frame untouched
    tbl.push_back(mk(0, 1, 1, 1,   1, 0, 3, 0, 1, 116));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 1, 0,   0, 1, 1, 0, 0, 6));
    // overlapping windows on instance B
    tbl.push_back(mk(1, 1, 0, 1,   1, 0, 0, 0, 0, 0));
    tbl.push_back(mk(1, 0, 1, 0,   0, 1, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 1, 0,   0, 1, 1, 0, 0, 3));
    tbl.push_back(mk(1, 0, 1, 0,   0, 1, 2, 0, 0, 5));
    tbl.push_back(mk(1, 0, 1, 0,   1, 1, 3, 1, 0, 7));

    a_load = 0; a_read = 0; a_frame = '0;
    b_load = 0; b_read = 0; b_frame = '0;

    #2;
    check_reset_values("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    for (int i = 0; i < tbl.size(); i++) run_vec(i, tbl[i]);

    // Instance A is now ACTIVE after two windows; assert reset mid-cycle
    a_load = 0; a_read = 0; b_load = 0; b_read = 0;
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    $display("mid-cycle reset: empty=%0d valid=%0d idx=%0d", a_empty, a_valid, a_idx);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    a_read = 1;
    @(posedge clk);
    #1;
    a_read = 0;
    check("post_rst_uf",    128'(a_uf),    128'(1));
    check("post_rst_valid", 128'(a_valid), 128'(0));
    check("post_rst_empty", 128'(a_empty), 128'(1));
    check("post_rst_group", 128'(a_group), 128'(0));
    $display("read after reset: uf=%0d valid=%0d empty=%0d", a_uf, a_valid, a_empty);
    @(posedge clk);
    #1;
    check("post_rst_uf_pulse", 128'(a_uf), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
